i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- Audio input front end of the channel strip; sits directly upstream of the lowpass stage.
- Oversamples an external I2S link (BCLK, LRCLK, SDATA) on the system clock and deserializes signed 16-bit left/right samples.
- Presents each stereo frame as a parallel word pair with a one-cycle valid strobe; rightOut/leftOut drive the filter input at the 48 kHz frame rate.

Parameters:
- DATA_W, 16, captured sample width (two's complement, MSB first).
- SLOT_W, 32, BCLK periods per channel slot; constraint SLOT_W >= DATA_W+1.
- SYNC_STAGES, 2, synchronizer flops on each I2S input; minimum 2.

Ports:
- clk  input  1  system clock; at least 4x BCLK.
- reset_n  input  1  synchronous, active-low reset.
- i2sBclk  input  1  I2S bit clock, asynchronous to clk.
- i2sLrclk  input  1  word select; 0 = left slot, 1 = right slot; asynchronous.
- i2sData  input  1  serial data; asynchronous.
- leftOut  output  DATA_W  signed left sample of the last complete frame.
- rightOut  output  DATA_W  signed right sample of the last complete frame.
- sampleValid  output  1  one-cycle pulse when leftOut/rightOut update.
- frameError  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (reset_n low at posedge clk): leftOut=0, rightOut=0, sampleValid=0, frameError=0, all synchronizers and shift registers cleared, state=WAIT_SYNC. Reset applied mid-frame abandons that frame silently: no valid, no error.
- Synchronize all three inputs through SYNC_STAGES flops. Edge detect uses synced value vs one extra delayed copy. bclkRise: 0->1. lrEdge: any change on LRCLK. lrFall: 1->0.
- Bit index: counter cleared to 0 on lrEdge; increments on each bclkRise; saturates at SLOT_W.
  - bclkRise at index 0 is the I2S one-bit delay (previous slot's trailing bit) and is ignored.
  - Indices 1..DATA_W are shifted in MSB first, sampling synced data in the bclkRise cycle.
  - Indices > DATA_W are ignored.
- Simultaneous lrEdge and bclkRise in the same clk: lrEdge processed first. Counter goes to 0, and that bclkRise is treated as index 0 of the new slot.
- A slot is complete when the counter reaches DATA_W+1 before the next lrEdge.
- States:
  - WAIT_SYNC: ignore data. On lrFall, go to LEFT.
  - LEFT (lrclk=0): shift into the left register.
    - On lrEdge: if the slot is complete, hold the left word and go to RIGHT.
    - Otherwise pulse frameError and go to WAIT_SYNC.
  - RIGHT (lrclk=1): shift into the right register.
    - On lrEdge with a complete slot: load leftOut and rightOut together in the same cycle, pulse sampleValid, go to LEFT (new left slot begins).
    - Incomplete slot: pulse frameError, no output update, go to WAIT_SYNC.
- An lrEdge in LEFT that is a rise is expected. An lrEdge in RIGHT that is a fall is expected. Any other polarity is impossible by construction, since edges alternate.
- Latency: sampleValid is high exactly SYNC_STAGES+2 clk cycles after the first posedge clk that samples the new i2sLrclk level. Outputs are registered and change only in that cycle. Outputs hold between frames.
- frameError and sampleValid are never high in the same cycle.
- Output width equals DATA_W. No saturation or scaling; bits are passed through exactly.

Decomposition:
- Shared audio package: DATA_W default, sample_t (logic signed [DATA_W-1:0]), rx state enum {WAIT_SYNC, LEFT, RIGHT}, FS_HZ = 48000.
- One natural sub-module, sync_edge: an N-stage synchronizer plus a rise/fall detector, instantiated once per I2S input. The FSM, bit counter and shift registers stay in i2s_rx.

Test Plan:
- Reset then idle: hold reset_n low 2 cycles, then drive nothing -> leftOut=0, rightOut=0, no sampleValid, no frameError.
- Nominal frame: BCLK = clk/8, SLOT_W=32, left=16'h7FFF, right=16'h8000. The first frame after reset is consumed by WAIT_SYNC -> the second frame gives leftOut=32767 and rightOut=-32768, with sampleValid high exactly SYNC_STAGES+2 cycles after the LRCLK fall, for one cycle.
- Sine stream: 16 frames of the 3 kHz half-scale sequence (0, 6270, 11585, 15136, 16383, ... negatives) -> each frame reproduces the pair exactly, one sampleValid per frame, frame spacing constant.
- Short slot: a right slot with only 10 BCLK rises -> one frameError pulse, outputs unchanged, no sampleValid. The next two clean frames resync, and the second produces valid output.
- Skew corner: align the LRCLK change and BCLK rise into the same synced cycle -> that rise counts as the delay bit; the captured word is 16'h1234, not shifted.
- Reset mid-frame: assert reset_n at bit 8 of a left slot -> all outputs 0 on the next cycle, no error pulse; clean capture resumes after the next LRCLK fall plus one full frame.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared audio definitions for the I2S receive front end.
package i2s_rx_pkg;
  localparam int AUDIO_W = 16;
  localparam int FS_HZ   = 48000;

  localparam int NUM_PINS  = 3;
  localparam int PIN_BCLK  = 0;
  localparam int PIN_LRCLK = 1;
  localparam int PIN_DATA  = 2;

  typedef logic signed [AUDIO_W-1:0] sample_t;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;
endpackage

// File: rtl/i2s_rx_sync_edge.sv
// N-stage synchronizer with registered rise/fall detect; level is the
// delayed copy, so it is time-aligned with the rise/fall flags.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// Oversampled I2S receiver: deserializes signed left/right words and
// presents each complete stereo frame with a one-cycle valid strobe.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W      = AUDIO_W,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i2sBclk,
  input  logic                     i2sLrclk,
  input  logic                     i2sData,
  output logic signed [DATA_W-1:0] leftOut,
  output logic signed [DATA_W-1:0] rightOut,
  output logic                     sampleValid,
  output logic                     frameError
);
  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W);

  logic [NUM_PINS-1:0] pin, lvl, rise, fall;

  assign pin = {i2sData, i2sLrclk, i2sBclk};

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (pin[g]),
      .level  (lvl[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  logic bclk_rise, lr_chg, lr_fall, sdata;
  assign bclk_rise = rise[PIN_BCLK];
  assign lr_chg    = rise[PIN_LRCLK] | fall[PIN_LRCLK];
  assign lr_fall   = fall[PIN_LRCLK];
  assign sdata     = lvl[PIN_DATA];

  logic unused_sync;
  assign unused_sync = ^{lvl[PIN_BCLK], lvl[PIN_LRCLK], fall[PIN_BCLK],
                         rise[PIN_DATA], fall[PIN_DATA]};

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] left_sr, right_sr;
  logic              slot_done, shift_en, commit, err;
  logic [1:0]        vld_pipe, err_pipe;

  assign slot_done = (cnt_q >= CNT_DONE);
  // Index 0 is the I2S delay bit; a rise coincident with an LRCLK edge
  // belongs to the new slot, so it never shifts.
  assign shift_en  = bclk_rise && !lr_chg && (cnt_q != '0) && (cnt_q <= CNT_LAST);

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    err     = 1'b0;
    case (state_q)
      WAIT_SYNC: if (lr_fall) state_d = LEFT;
      LEFT: begin
        if (lr_chg) begin
          if (slot_done) begin
            state_d = RIGHT;
          end else begin
            err     = 1'b1;
            state_d = WAIT_SYNC;
          end
        end
      end
      RIGHT: begin
        if (lr_chg) begin
          if (slot_done) begin
            commit  = 1'b1;
            state_d = LEFT;
          end else begin
            err     = 1'b1;
            state_d = WAIT_SYNC;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= WAIT_SYNC;
      cnt_q    <= '0;
      left_sr  <= '0;
      right_sr <= '0;
      vld_pipe <= '0;
      err_pipe <= '0;
      leftOut  <= '0;
      rightOut <= '0;
    end else begin
      state_q <= state_d;

      if (lr_chg)                            cnt_q <= bclk_rise ? CNT_W'(1) : '0;
      else if (bclk_rise && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);

      if (shift_en && state_q == LEFT)  left_sr  <= {left_sr[DATA_W-2:0], sdata};
      if (shift_en && state_q == RIGHT) right_sr <= {right_sr[DATA_W-2:0], sdata};

      // Shift registers stay quiet for several clk after a commit (next
      // shift needs a non-delay BCLK rise), so a one-cycle-late load is safe.
      vld_pipe <= {vld_pipe[0], commit};
      err_pipe <= {err_pipe[0], err};
      if (vld_pipe[0]) begin
        leftOut  <= left_sr;
        rightOut <= right_sr;
      end
    end
  end

  assign sampleValid = vld_pipe[1];
  assign frameError  = err_pipe[1];
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: BCLK = clk/8, frames built MSB first.
module tb_i2s_rx;
  localparam int DW = 16;
  localparam int SW = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i2sBclk = 1'b1, i2sLrclk = 1'b0, i2sData = 1'b0;
  logic [DW-1:0] leftOut, rightOut;
  logic          sampleValid, frameError;

  i2s_rx #(.DATA_W(DW), .SLOT_W(SW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i2sBclk    (i2sBclk),
    .i2sLrclk   (i2sLrclk),
    .i2sData    (i2sData),
    .leftOut    (leftOut),
    .rightOut   (rightOut),
    .sampleValid(sampleValid),
    .frameError (frameError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            at;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            checks = 0, errors = 0;
  int            nvalid = 0, nerr = 0, exp_valid = 0, exp_err = 0;
  logic [DW-1:0] last_l = '0, last_r = '0;
  logic          pend = 1'b0, skew = 1'b0;
  logic [DW-1:0] pend_l, pend_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  // The frame closes on the LRCLK fall that starts the next left slot.
  task automatic set_lr(input logic lr);
    exp_t x;
    i2sLrclk = lr;
    if (pend) begin
      x.l  = pend_l;
      x.r  = pend_r;
      x.at = cyc + 1 + SS + 2;
      q.push_back(x);
      exp_valid++;
      pend = 1'b0;
    end
  endtask

  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nrise);
    for (int i = 0; i < nrise; i++) begin
      i2sBclk = 1'b0;
      if (i == 0 && !skew) set_lr(lr);
      if (i == 0)                    i2sData = 1'b1;
      else if (i <= DW)              i2sData = w[DW-i];
      else                           i2sData = 1'b0;
      half();
      i2sBclk = 1'b1;
      if (i == 0 && skew) set_lr(lr);
      half();
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic expv);
    send_slot(1'b0, l, SW);
    send_slot(1'b1, r, SW);
    pend   = expv;
    pend_l = l;
    pend_r = r;
  endtask

  always @(negedge clk) begin
    if (sampleValid) begin
      chk("excl", 32'(frameError), 32'd0);
      if (q.size() == 0) begin
        chk("q_nonempty", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("left", 32'(leftOut), 32'(e.l));
        chk("right", 32'(rightOut), 32'(e.r));
        chk("latency", cyc, e.at);
        last_l = e.l;
        last_r = e.r;
        nvalid++;
      end
    end
    if (frameError) begin
      nerr++;
      chk("err_hold_l", 32'(leftOut), 32'(last_l));
      chk("err_hold_r", 32'(rightOut), 32'(last_r));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int sine[16] = '{0, 6270, 11585, 15136, 16383, 15136, 11585, 6270,
                   0, -6270, -11585, -15136, -16383, -15136, -11585, -6270};

  initial begin
    logic [DW-1:0] s;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_left", 32'(leftOut), 32'd0);
    chk("idle_right", 32'(rightOut), 32'd0);
    chk("idle_valid", nvalid, 0);
    chk("idle_err", nerr, 0);

    // first frame only synchronizes
    send_frame(16'h7FFF, 16'h8000, 1'b0);
    send_frame(16'h7FFF, 16'h8000, 1'b1);

    for (int k = 0; k < 16; k++) begin
      s = DW'(sine[k]);
      send_frame(s, -s, 1'b1);
    end

    // right slot with only 10 rises
    send_slot(1'b0, 16'h1111, SW);
    send_slot(1'b1, 16'h2222, 10);
    exp_err++;
    send_frame(16'hA5A5, 16'h5A5A, 1'b0);
    send_frame(16'h0F0F, 16'hF0F0, 1'b1);

    skew = 1'b1;
    send_frame(16'h1234, 16'h4321, 1'b1);
    skew = 1'b0;

    // reset at bit 8 of a left slot
    send_slot(1'b0, 16'hDEAD, 8);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_left", 32'(leftOut), 32'd0);
    chk("rst_right", 32'(rightOut), 32'd0);
    chk("rst_valid", 32'(sampleValid), 32'd0);
    chk("rst_err", 32'(frameError), 32'd0);
    last_l = '0;
    last_r = '0;
    reset_n = 1'b1;
    send_slot(1'b1, 16'h5555, SW);
    send_frame(16'hBEEF, 16'h0123, 1'b1);
    send_slot(1'b0, 16'h0000, SW);
    repeat (20) @(negedge clk);

    chk("valid_cnt", nvalid, exp_valid);
    chk("err_cnt", nerr, exp_err);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
